// File: rtl/rv_muldiv_unit_pkg.sv
// ----------------------------------------------------------------------------
// rv_muldiv_unit_pkg
// Shared types and constants for the iterative RV32M/RV64M multiply/divide
// unit: funct3 encodings of the eight M-extension operations, the FSM state
// type and the default operand width.
// Ports: none (package).
// ----------------------------------------------------------------------------
package rv_muldiv_unit_pkg;

    localparam int MDU_XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_func;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state;

endpackage

// File: rtl/rv_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// rv_muldiv_unit_if
// Issue/result bundle of the multiply/divide unit.
//   in_valid/in_ready  : operation handshake (func, rs1, rs2, tag_in)
//   flush              : kill of the in-flight operation
//   out_valid/out_ready: result handshake (result, tag_out)
// master = issuing execute stage, slave = the unit.
// ----------------------------------------------------------------------------
interface rv_muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       func;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, func, rs1, rs2, tag_in, flush, out_ready,
        input  in_ready, out_valid, result, tag_out
    );

    modport slave (
        input  in_valid, func, rs1, rs2, tag_in, flush, out_ready,
        output in_ready, out_valid, result, tag_out
    );
endinterface

// File: rtl/rv_muldiv_unit_step.sv
// ----------------------------------------------------------------------------
// rv_muldiv_step
// One combinational iteration of the unit, shared by both operation kinds.
// The accumulator is 2*XLEN+1 bits wide:
//   multiply: {carry, partial product high, multiplier remainder}; one
//             shift-add step per call (right shift).
//   divide  : {partial remainder (XLEN+1 bits), dividend/quotient (XLEN)};
//             one restoring-divide step per call (left shift).
// Ports: is_div (mode), acc_in, operand (multiplicand or divisor), acc_out.
// ----------------------------------------------------------------------------
module rv_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN:0]   acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN:0]   acc_out
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted_rem;
    logic [XLEN:0] diff;

    always_comb begin
        // Top bit is always zero between steps, so the add cannot overflow.
        sum         = acc_in[2*XLEN:XLEN] + (acc_in[0] ? {1'b0, operand} : '0);
        shifted_rem = acc_in[2*XLEN-1:XLEN-1];
        // Partial remainder is below 2*divisor, so diff's MSB is a clean borrow.
        diff        = shifted_rem - {1'b0, operand};
        if (is_div) begin
            if (diff[XLEN]) begin
                acc_out = {shifted_rem, acc_in[XLEN-2:0], 1'b0};
            end else begin
                acc_out = {diff, acc_in[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_out = {1'b0, sum, acc_in[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/rv_muldiv_unit.sv
// ----------------------------------------------------------------------------
// rv_muldiv_unit
// Iterative M-extension multiply/divide unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU). Operands are reduced to magnitudes on accept, the
// magnitude is processed STEPS bits per clock for XLEN/STEPS clocks, then the
// sign is restored and the result word selected. Divide-by-zero and signed
// overflow are resolved at accept and skip the iteration entirely.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of rv_muldiv_unit_if (issue/result handshakes,
//              flush)
// ----------------------------------------------------------------------------
module rv_muldiv_unit
    import rv_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = MDU_XLEN_DEFAULT,
    parameter int STEPS = 1,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    rv_muldiv_unit_if.slave bus
);
    localparam int N     = XLEN / STEPS;
    localparam int CNT_W = $clog2(N);

    mdu_state           state;
    logic [CNT_W-1:0]   cnt;
    mdu_func            func_r;
    logic [TAG_W-1:0]   tag_r;
    logic               neg_r;
    logic [2*XLEN:0]    acc;
    logic [XLEN-1:0]    opb;
    logic [XLEN-1:0]    result_r;
    logic               out_valid_r;

    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                  input logic neg);
        return neg ? -v : v;
    endfunction

    // Accept-time decode
    mdu_func          f_in;
    logic             a_neg, b_neg, neg_in;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             div_zero, sgn_ovf;
    logic [XLEN-1:0]  special_res;
    logic             ready_int;

    always_comb begin
        f_in     = mdu_func'(bus.func);
        a_neg    = bus.rs1[XLEN-1] &&
                   (f_in inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
        b_neg    = bus.rs2[XLEN-1] && (f_in inside {MDU_MULH, MDU_DIV, MDU_REM});
        // Remainder follows the dividend; everything else follows the product sign.
        neg_in   = (f_in == MDU_REM) ? a_neg : (a_neg ^ b_neg);
        a_mag    = magnitude(bus.rs1, a_neg);
        b_mag    = magnitude(bus.rs2, b_neg);
        div_zero = f_in[2] && (bus.rs2 == '0);
        sgn_ovf  = (f_in inside {MDU_DIV, MDU_REM}) &&
                   (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
        // func[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_zero) begin
            special_res = f_in[1] ? bus.rs1 : '1;
        end else begin
            special_res = f_in[1] ? '0 : bus.rs1;
        end
    end

    // Iteration chain
    logic [2*XLEN:0] chain [STEPS+1];
    assign chain[0] = acc;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        rv_muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div  (func_r[2]),
            .acc_in  (chain[g]),
            .operand (opb),
            .acc_out (chain[g+1])
        );
    end

    // Sign restore and result select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel, div_fix, fix_res;

    always_comb begin
        prod_fix = neg_r ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
        div_sel  = func_r[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        div_fix  = neg_r ? -div_sel : div_sel;
        if (func_r[2]) begin
            fix_res = div_fix;
        end else if (func_r == MDU_MUL) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    assign ready_int     = (state == IDLE) && !bus.flush;
    assign bus.in_ready  = ready_int;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.tag_out   = tag_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            func_r      <= MDU_MUL;
            tag_r       <= '0;
            neg_r       <= 1'b0;
            acc         <= '0;
            opb         <= '0;
            result_r    <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && ready_int) begin
                        func_r <= f_in;
                        tag_r  <= bus.tag_in;
                        neg_r  <= neg_in;
                        cnt    <= CNT_W'(N - 1);
                        // Multiply: multiplier in the low half, multiplicand as operand.
                        // Divide: dividend in the low half, divisor as operand.
                        acc    <= {{(XLEN+1){1'b0}}, (f_in[2] ? a_mag : b_mag)};
                        opb    <= f_in[2] ? b_mag : a_mag;
                        if (div_zero || sgn_ovf) begin
                            result_r    <= special_res;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= chain[STEPS];
                        if (cnt == '0) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                FIX: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        result_r    <= fix_res;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.flush || bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_rv_muldiv_unit
// Directed vectors for rv_muldiv_unit. A STEPS=1 instance is driven through
// a scoreboard (expected result, tag and latency queued at accept, popped by
// a monitor when out_valid appears); a STEPS=4 instance checks the shorter
// latency inline.
// ----------------------------------------------------------------------------
module tb_rv_muldiv_unit;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];

    rv_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) m1 ();
    rv_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) m4 ();

    rv_muldiv_unit #(.XLEN(32), .STEPS(1), .TAG_W(5)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (m1)
    );

    rv_muldiv_unit #(.XLEN(32), .STEPS(4), .TAG_W(5)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (m4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops one expectation per result and checks stability while held.
    initial begin : monitor
        exp_t        e;
        bit          seen;
        logic [31:0] hr;
        logic [4:0]  ht;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (m1.out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    hr   = m1.result;
                    ht   = m1.tag_out;
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_out_valid", 64'(m1.result), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check(m1.result == e.res, "result", 64'(m1.result), 64'(e.res));
                        check(m1.tag_out == e.tag, "tag_out", 64'(m1.tag_out), 64'(e.tag));
                        check((cyc - e.acc_cyc + 1) == e.lat, "latency",
                              64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                    end
                end else begin
                    check(m1.result == hr && m1.tag_out == ht, "hold_stable",
                          {27'd0, m1.tag_out, m1.result}, {27'd0, ht, hr});
                end
                if (m1.out_ready) seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input bit push,
                         input logic [31:0] eres, input int elat);
        int w;
        w = 0;
        @(negedge clk);
        while (!m1.in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!m1.in_ready) begin
            check(1'b0, "issue_timeout", 64'(w), 64'(300));
            return;
        end
        m1.in_valid = 1'b1;
        m1.func     = f;
        m1.rs1      = a;
        m1.rs2      = b;
        m1.tag_in   = t;
        @(posedge clk);
        #1;
        m1.in_valid = 1'b0;
        if (push) sb.push_back('{eres, t, elat, cyc});
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m1.out_valid) return;
        end
        check(1'b0, "wait_valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check(sb.size() == 0, "drain", 64'(sb.size()), 64'(0));
        @(negedge clk);
    endtask

    task automatic run4(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [31:0] eres);
        int lat;
        @(negedge clk);
        check(m4.in_ready == 1'b1, "s4_in_ready", 64'(m4.in_ready), 64'(1));
        m4.in_valid = 1'b1;
        m4.func     = f;
        m4.rs1      = a;
        m4.rs2      = b;
        m4.tag_in   = t;
        @(posedge clk);
        #1;
        m4.in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m4.out_valid) break;
            @(posedge clk);
            lat++;
        end
        check(m4.out_valid == 1'b1, "s4_out_valid", 64'(m4.out_valid), 64'(1));
        check(lat == 10, "s4_latency", 64'(lat), 64'(10));
        check(m4.result == eres, "s4_result", 64'(m4.result), 64'(eres));
        check(m4.tag_out == t, "s4_tag", 64'(m4.tag_out), 64'(t));
    endtask

    initial begin : stimulus
        rst = 1'b1;
        m1.in_valid = 1'b0; m1.func = 3'd0; m1.rs1 = '0; m1.rs2 = '0;
        m1.tag_in = '0; m1.flush = 1'b0; m1.out_ready = 1'b1;
        m4.in_valid = 1'b0; m4.func = 3'd0; m4.rs1 = '0; m4.rs2 = '0;
        m4.tag_in = '0; m4.flush = 1'b0; m4.out_ready = 1'b1;
        #22;
        rst = 1'b0;

        @(negedge clk);
        check(m1.in_ready == 1'b1, "reset_in_ready", 64'(m1.in_ready), 64'(1));
        check(m1.out_valid == 1'b0, "reset_out_valid", 64'(m1.out_valid), 64'(0));
        check(m1.result == 32'd0, "reset_result", 64'(m1.result), 64'(0));
        check(m1.tag_out == 5'd0, "reset_tag_out", 64'(m1.tag_out), 64'(0));

        // Multiplies
        issue(3'b000, 32'd7,        32'hFFFF_FFFD, 5'h0A, 1, 32'hFFFF_FFEB, 34);
        issue(3'b001, 32'd7,        32'hFFFF_FFFD, 5'h0B, 1, 32'hFFFF_FFFF, 34);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h0C, 1, 32'hFFFF_FFFE, 34);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h0D, 1, 32'hFFFF_FFFF, 34);
        issue(3'b011, 32'h8000_0000, 32'd2,        5'h0E, 1, 32'h0000_0001, 34);
        // Divides
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,        5'h0F, 1, 32'hFFFF_FFFD, 34);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,        5'h10, 1, 32'hFFFF_FFFF, 34);
        issue(3'b101, 32'd1000,      32'd7,        5'h16, 1, 32'd142,       34);
        issue(3'b111, 32'd1000,      32'd7,        5'h17, 1, 32'd6,         34);
        issue(3'b100, 32'd20,        32'hFFFF_FFFA, 5'h18, 1, 32'hFFFF_FFFD, 34);
        issue(3'b110, 32'd20,        32'hFFFF_FFFA, 5'h08, 1, 32'd2,         34);
        // Special cases
        issue(3'b101, 32'd100,       32'd0,        5'h11, 1, 32'hFFFF_FFFF, 1);
        issue(3'b111, 32'd100,       32'd0,        5'h12, 1, 32'd100,       1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'h13, 1, 32'h8000_0000, 1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'h14, 1, 32'd0,         1);
        issue(3'b110, 32'hFFFF_FFF9, 32'd0,        5'h15, 1, 32'hFFFF_FFF9, 1);
        drain();

        // Backpressure in DONE
        m1.out_ready = 1'b0;
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'h19, 1, 32'hFFFF_FFFD, 34);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check(m1.out_valid && !m1.in_ready && m1.result == 32'hFFFF_FFFD &&
                  m1.tag_out == 5'h19, "backpressure_hold",
                  {30'd0, m1.out_valid, m1.in_ready, m1.result}, {30'd0, 2'b10, 32'hFFFF_FFFD});
            @(posedge clk);
            #1;
        end
        m1.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(m1.in_ready && !m1.out_valid, "after_handshake_ready",
              {m1.in_ready, m1.out_valid}, 64'b10);

        // flush in IDLE blocks the accept
        m1.in_valid = 1'b1; m1.func = 3'b101; m1.rs1 = 32'd5; m1.rs2 = 32'd0;
        m1.tag_in = 5'h1E; m1.flush = 1'b1;
        #1;
        check(m1.in_ready == 1'b0, "idle_flush_blocks", 64'(m1.in_ready), 64'(0));
        @(posedge clk);
        #1;
        m1.in_valid = 1'b0;
        m1.flush    = 1'b0;
        @(negedge clk);
        check(m1.in_ready && !m1.out_valid, "idle_flush_no_accept",
              {m1.in_ready, m1.out_valid}, 64'b10);

        // flush during CALC iteration 10
        issue(3'b101, 32'd1000, 32'd7, 5'h1A, 0, 32'd0, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        m1.flush = 1'b1;
        #1;
        check(m1.out_valid == 1'b0, "flush_calc_no_valid", 64'(m1.out_valid), 64'(0));
        @(posedge clk);
        #1;
        m1.flush = 1'b0;
        @(negedge clk);
        check(m1.in_ready == 1'b1, "flush_calc_ready", 64'(m1.in_ready), 64'(1));
        issue(3'b101, 32'd9, 32'd3, 5'h1B, 1, 32'd3, 34);
        drain();

        // Asynchronous reset mid-CALC
        issue(3'b000, 32'd5, 32'd6, 5'h1C, 0, 32'd0, 0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check(m1.out_valid == 1'b0, "async_rst_out_valid", 64'(m1.out_valid), 64'(0));
        check(m1.result == 32'd0, "async_rst_result", 64'(m1.result), 64'(0));
        check(m1.tag_out == 5'd0, "async_rst_tag_out", 64'(m1.tag_out), 64'(0));
        #3;
        rst = 1'b0;
        @(negedge clk);
        check(m1.in_ready && !m1.out_valid, "after_rst_idle",
              {m1.in_ready, m1.out_valid}, 64'b10);
        issue(3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 5'h1D, 1, 32'hFFFE_0001, 34);
        drain();

        // STEPS=4 instance
        run4(3'b000, 32'h0001_2345, 32'h0000_0100, 5'h05, 32'h0123_4500);
        run4(3'b001, 32'h8000_0000, 32'h8000_0000, 5'h06, 32'h4000_0000);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
